zynq_axil_fifo_csr: RTL and testbench

- AXI4-Lite slave endpoint sitting directly downstream of the PS-side s00_axi port inside top_zynq.
- Terminates host (PS) register traffic and exposes it to PL logic as:
  - num_regs_p read/write CSRs, exported in parallel.
  - A PS-to-PL word FIFO.
  - A PL-to-PS word FIFO.
- Read and write channels operate independently; AW and W may arrive in any order.

---
 rtl/zynq_axil_fifo_csr_if.sv | 37 +++
 rtl/zynq_axil_fifo_csr.sv | 255 +++++++++++++++++++++++++
 tb/tb_zynq_axil_fifo_csr.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zynq_axil_fifo_csr_if.sv
// AXI4-Lite bus bundle between the PS s00_axi port and zynq_axil_fifo_csr.
// master: host side (drives AW/W/AR, accepts B/R); slave: endpoint side.
interface zynq_axil_fifo_csr_if #(
  parameter int addr_width_p = 10
) ();
  logic [addr_width_p-1:0] awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [31:0]             wdata;
  logic [3:0]              wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [addr_width_p-1:0] araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [31:0]             rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/zynq_axil_fifo_csr.sv
// AXI4-Lite slave terminating PS register traffic into PL-facing resources:
// num_regs_p RW CSRs, a PS-to-PL word FIFO and a PL-to-PS word FIFO.
// Ports:
//   aclk, aresetn      clock, async active-low reset
//   s00_axi            AXI4-Lite slave bundle
//   csr_data_o         all CSRs, reg i at [32i+31:32i]
//   ps_to_pl_*         FIFO head / valid / yumi (pop)
//   pl_to_ps_*         FIFO push data / valid / ready
// Map (word): 0 free slots (RO), 1 enqueue (WO), 2 occupancy (RO),
//             3 dequeue (RO, pops), 4+i CSR i (RW).
module zynq_axil_fifo_csr #(
  parameter int addr_width_p = 10,
  parameter int data_width_p = 32,
  parameter int num_regs_p   = 4,
  parameter int fifo_els_p   = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  zynq_axil_fifo_csr_if.slave      s00_axi,
  output logic [num_regs_p*32-1:0] csr_data_o,
  output logic [31:0]              ps_to_pl_data_o,
  output logic                     ps_to_pl_v_o,
  input  logic                     ps_to_pl_yumi_i,
  input  logic [31:0]              pl_to_ps_data_i,
  input  logic                     pl_to_ps_v_i,
  output logic                     pl_to_ps_ready_o
);

  localparam int cnt_w_lp  = $clog2(fifo_els_p + 1);
  localparam int ptr_w_lp  = $clog2(fifo_els_p);
  localparam int word_w_lp = addr_width_p - 2;
  localparam logic [cnt_w_lp-1:0]  els_lp   = cnt_w_lp'(fifo_els_p);
  localparam logic [word_w_lp-1:0] free_lp  = word_w_lp'(0);
  localparam logic [word_w_lp-1:0] enq_lp   = word_w_lp'(1);
  localparam logic [word_w_lp-1:0] occ_lp   = word_w_lp'(2);
  localparam logic [word_w_lp-1:0] deq_lp   = word_w_lp'(3);
  localparam logic [word_w_lp-1:0] csr0_lp  = word_w_lp'(4);
  localparam logic [1:0]           okay_lp  = 2'b00;
  localparam logic [1:0]           slverr_lp = 2'b10;

  if (data_width_p != 32) begin : g_bad_width
    $error("zynq_axil_fifo_csr: only 32-bit data is supported");
  end
  if (num_regs_p < 1 || num_regs_p > 16) begin : g_bad_regs
    $error("zynq_axil_fifo_csr: num_regs_p must be 1..16");
  end

  // live_q keeps every ready low until the first edge after reset release.
  logic                 live_q, live_d;
  logic                 aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [word_w_lp-1:0] aw_word_q, aw_word_d;
  logic [31:0]          w_data_q, w_data_d;
  logic [3:0]           w_strb_q, w_strb_d;
  logic                 bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]           bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [31:0]          csr_q [num_regs_p];
  logic [31:0]          csr_d [num_regs_p];
  logic [31:0]          p2l_mem_q [fifo_els_p];
  logic [31:0]          p2l_mem_d [fifo_els_p];
  logic [31:0]          l2p_mem_q [fifo_els_p];
  logic [31:0]          l2p_mem_d [fifo_els_p];
  logic [ptr_w_lp-1:0]  p2l_rd_q, p2l_rd_d, p2l_wr_q, p2l_wr_d;
  logic [ptr_w_lp-1:0]  l2p_rd_q, l2p_rd_d, l2p_wr_q, l2p_wr_d;
  logic [cnt_w_lp-1:0]  p2l_cnt_q, p2l_cnt_d, l2p_cnt_q, l2p_cnt_d;

  logic awready, wready, arready, aw_hs, w_hs, ar_hs, commit;
  logic p2l_push, p2l_pop, l2p_push, l2p_pop;
  logic [word_w_lp-1:0] ar_word;
  logic unused_prot;

  assign unused_prot = ^{s00_axi.awprot, s00_axi.arprot};

  assign awready = live_q & ~aw_full_q;
  assign wready  = live_q & ~w_full_q;
  assign arready = live_q & ~rvalid_q;
  assign aw_hs   = s00_axi.awvalid & awready;
  assign w_hs    = s00_axi.wvalid & wready;
  assign ar_hs   = s00_axi.arvalid & arready;

  assign s00_axi.awready = awready;
  assign s00_axi.wready  = wready;
  assign s00_axi.arready = arready;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.bresp   = bresp_q;
  assign s00_axi.rvalid  = rvalid_q;
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = rresp_q;

  assign ps_to_pl_v_o     = (p2l_cnt_q != '0);
  assign ps_to_pl_data_o  = ps_to_pl_v_o ? p2l_mem_q[p2l_rd_q] : '0;
  assign pl_to_ps_ready_o = live_q & (l2p_cnt_q != els_lp);

  for (genvar g = 0; g < num_regs_p; g++) begin : g_csr_out
    assign csr_data_o[32*g +: 32] = csr_q[g];
  end

  always_comb begin
    live_d    = 1'b1;
    aw_full_d = aw_full_q;
    aw_word_d = aw_word_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    csr_d     = csr_q;
    p2l_mem_d = p2l_mem_q;
    l2p_mem_d = l2p_mem_q;
    p2l_rd_d  = p2l_rd_q;
    p2l_wr_d  = p2l_wr_q;
    p2l_cnt_d = p2l_cnt_q;
    l2p_rd_d  = l2p_rd_q;
    l2p_wr_d  = l2p_wr_q;
    l2p_cnt_d = l2p_cnt_q;
    p2l_push  = 1'b0;
    l2p_pop   = 1'b0;
    ar_word   = s00_axi.araddr[addr_width_p-1:2];
    commit    = aw_full_q & w_full_q & ~bvalid_q;
    p2l_pop   = ps_to_pl_yumi_i & (p2l_cnt_q != '0);

    // write channel
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_word_d = s00_axi.awaddr[addr_width_p-1:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = s00_axi.wdata;
      w_strb_d = s00_axi.wstrb;
    end
    if (bvalid_q && s00_axi.bready) bvalid_d = 1'b0;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = slverr_lp;
      // a same-edge yumi frees the slot the enqueue needs
      if (aw_word_q == enq_lp && (p2l_cnt_q != els_lp || p2l_pop)) begin
        p2l_push = 1'b1;
        bresp_d  = okay_lp;
      end
      for (int i = 0; i < num_regs_p; i++) begin
        if (aw_word_q == csr0_lp + word_w_lp'(i)) begin
          bresp_d = okay_lp;
          for (int b = 0; b < 4; b++) begin
            if (w_strb_q[b]) csr_d[i][8*b +: 8] = w_data_q[8*b +: 8];
          end
        end
      end
    end

    // read channel
    if (rvalid_q && s00_axi.rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = slverr_lp;
      if (ar_word == free_lp) begin
        rdata_d = 32'(els_lp - p2l_cnt_q);
        rresp_d = okay_lp;
      end else if (ar_word == occ_lp) begin
        rdata_d = 32'(l2p_cnt_q);
        rresp_d = okay_lp;
      end else if (ar_word == deq_lp) begin
        if (l2p_cnt_q != '0) begin
          rdata_d = l2p_mem_q[l2p_rd_q];
          rresp_d = okay_lp;
          l2p_pop = 1'b1;
        end
      end
      for (int i = 0; i < num_regs_p; i++) begin
        if (ar_word == csr0_lp + word_w_lp'(i)) begin
          rdata_d = csr_q[i];
          rresp_d = okay_lp;
        end
      end
    end

    // a full PL-to-PS FIFO still takes a push on the edge the host pops it
    l2p_push = pl_to_ps_v_i & live_q & ((l2p_cnt_q != els_lp) | l2p_pop);

    if (p2l_push) begin
      p2l_mem_d[p2l_wr_q] = w_data_q;
      p2l_wr_d = p2l_wr_q + ptr_w_lp'(1);
    end
    if (p2l_pop) p2l_rd_d = p2l_rd_q + ptr_w_lp'(1);
    if (p2l_push && !p2l_pop) p2l_cnt_d = p2l_cnt_q + cnt_w_lp'(1);
    else if (!p2l_push && p2l_pop) p2l_cnt_d = p2l_cnt_q - cnt_w_lp'(1);

    if (l2p_push) begin
      l2p_mem_d[l2p_wr_q] = pl_to_ps_data_i;
      l2p_wr_d = l2p_wr_q + ptr_w_lp'(1);
    end
    if (l2p_pop) l2p_rd_d = l2p_rd_q + ptr_w_lp'(1);
    if (l2p_push && !l2p_pop) l2p_cnt_d = l2p_cnt_q + cnt_w_lp'(1);
    else if (!l2p_push && l2p_pop) l2p_cnt_d = l2p_cnt_q - cnt_w_lp'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      live_q    <= 1'b0;
      aw_full_q <= 1'b0;
      aw_word_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      for (int i = 0; i < num_regs_p; i++) csr_q[i] <= '0;
      for (int i = 0; i < fifo_els_p; i++) begin
        p2l_mem_q[i] <= '0;
        l2p_mem_q[i] <= '0;
      end
      p2l_rd_q  <= '0;
      p2l_wr_q  <= '0;
      p2l_cnt_q <= '0;
      l2p_rd_q  <= '0;
      l2p_wr_q  <= '0;
      l2p_cnt_q <= '0;
    end else begin
      live_q    <= live_d;
      aw_full_q <= aw_full_d;
      aw_word_q <= aw_word_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      csr_q     <= csr_d;
      p2l_mem_q <= p2l_mem_d;
      l2p_mem_q <= l2p_mem_d;
      p2l_rd_q  <= p2l_rd_d;
      p2l_wr_q  <= p2l_wr_d;
      p2l_cnt_q <= p2l_cnt_d;
      l2p_rd_q  <= l2p_rd_d;
      l2p_wr_q  <= l2p_wr_d;
      l2p_cnt_q <= l2p_cnt_d;
    end
  end

  a_yumi_nonempty: assert property (@(posedge aclk) disable iff (!aresetn)
    ps_to_pl_yumi_i |-> ps_to_pl_v_o)
    else $error("ps_to_pl_yumi_i asserted while FIFO empty");

endmodule

// File: tb/tb_zynq_axil_fifo_csr.sv
module tb_zynq_axil_fifo_csr;
  localparam int AW = 10;
  localparam int NR = 4;
  localparam int EL = 8;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  zynq_axil_fifo_csr_if #(.addr_width_p(AW)) axi ();
  logic [NR*32-1:0] csr_data;
  logic [31:0] p2l_data, l2p_data;
  logic p2l_v, p2l_yumi, l2p_v, l2p_ready;

  zynq_axil_fifo_csr #(.addr_width_p(AW), .data_width_p(32), .num_regs_p(NR), .fifo_els_p(EL)) dut (
    .aclk(aclk), .aresetn(aresetn), .s00_axi(axi), .csr_data_o(csr_data),
    .ps_to_pl_data_o(p2l_data), .ps_to_pl_v_o(p2l_v), .ps_to_pl_yumi_i(p2l_yumi),
    .pl_to_ps_data_i(l2p_data), .pl_to_ps_v_i(l2p_v), .pl_to_ps_ready_o(l2p_ready));

  int n_tests = 0;
  int n_fail = 0;

  // reference model
  logic [31:0] m_csr [NR];
  logic [31:0] m_p2l [$];
  logic [31:0] m_l2p [$];

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  function automatic logic [NR*32-1:0] csr_vec();
    logic [NR*32-1:0] v;
    for (int i = 0; i < NR; i++) v[32*i +: 32] = m_csr[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_csr[i] = '0;
    m_p2l.delete();
    m_l2p.delete();
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, a_now, w_now, got;
    int n;
    axi.awaddr = addr; axi.wdata = data; axi.wstrb = strb;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b1;
    aw_done = 0; w_done = 0; got = 0; n = 0; resp = 2'bxx;
    while (!(aw_done && w_done) && n < 50) begin
      a_now = axi.awvalid && axi.awready;
      w_now = axi.wvalid && axi.wready;
      tick();
      if (a_now) begin aw_done = 1; axi.awvalid = 1'b0; end
      if (w_now) begin w_done = 1; axi.wvalid = 1'b0; end
      n++;
    end
    while (!got && n < 100) begin
      if (axi.bvalid) begin resp = axi.bresp; got = 1; end
      tick();
      n++;
    end
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL write_timeout addr=%h got no bvalid, required bvalid within 100 cycles", addr);
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bit ar_done, a_now, got;
    int n;
    axi.araddr = addr; axi.arvalid = 1'b1; axi.rready = 1'b1;
    ar_done = 0; got = 0; n = 0; data = 'x; resp = 2'bxx;
    while (!ar_done && n < 50) begin
      a_now = axi.arvalid && axi.arready;
      tick();
      if (a_now) begin ar_done = 1; axi.arvalid = 1'b0; end
      n++;
    end
    while (!got && n < 100) begin
      if (axi.rvalid) begin data = axi.rdata; resp = axi.rresp; got = 1; end
      tick();
      n++;
    end
    axi.arvalid = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL read_timeout addr=%h got no rvalid, required rvalid within 100 cycles", addr);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    aresetn = 1'b0;
    axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0; axi.bready = 1; axi.rready = 1;
    axi.awaddr = '0; axi.araddr = '0; axi.wdata = '0; axi.wstrb = '0;
    axi.awprot = '0; axi.arprot = '0;
    p2l_yumi = 0; l2p_v = 0; l2p_data = '0;
    model_reset();
    tick(); tick();
    n_tests++;
    if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, p2l_v, l2p_ready} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b required=0000000",
               {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, p2l_v, l2p_ready});
    end
    n_tests++;
    if ({axi.bresp, axi.rresp, axi.rdata, p2l_data, csr_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got bresp=%b rresp=%b rdata=%h p2l=%h csr=%h required all 0",
               axi.bresp, axi.rresp, axi.rdata, p2l_data, csr_data);
    end
    aresetn = 1'b1;
    tick();
    n_tests++;
    if ({axi.awready, axi.wready, axi.arready, l2p_ready} !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_release got=%b required=1111",
               {axi.awready, axi.wready, axi.arready, l2p_ready});
    end
    axi_read(10'h000, d, r);
    n_tests++;
    if (d !== 32'(EL - m_p2l.size()) || r !== OKAY) begin
      n_fail++; $display("FAIL reset_free got=%h/%b required=%h/00", d, r, EL - m_p2l.size());
    end
    axi_read(10'h008, d, r);
    n_tests++;
    if (d !== 32'(m_l2p.size()) || r !== OKAY) begin
      n_fail++; $display("FAIL reset_occ got=%h/%b required=%h/00", d, r, m_l2p.size());
    end
    axi_read(10'h010, d, r);
    n_tests++;
    if (d !== m_csr[0] || r !== OKAY) begin
      n_fail++; $display("FAIL reset_csr0 got=%h/%b required=%h/00", d, r, m_csr[0]);
    end
  endtask

  task automatic test_w_before_aw();
    axi.bready = 1'b1;
    axi.wdata = 32'hA5A5_A5A5; axi.wstrb = 4'b0011; axi.wvalid = 1'b1;
    tick();
    axi.wvalid = 1'b0;
    tick(); tick();
    axi.awaddr = 10'h014; axi.awvalid = 1'b1;
    n_tests++;
    if (axi.awready !== 1'b1) begin
      n_fail++; $display("FAIL wfirst_awready got=%b required=1", axi.awready);
    end
    tick();
    axi.awvalid = 1'b0;
    n_tests++;
    if (axi.bvalid !== 1'b0) begin
      n_fail++; $display("FAIL wfirst_bvalid_early got=%b required=0", axi.bvalid);
    end
    tick();
    m_csr[1] = merge(m_csr[1], 32'hA5A5_A5A5, 4'b0011);
    n_tests++;
    if (axi.bvalid !== 1'b1 || axi.bresp !== OKAY) begin
      n_fail++; $display("FAIL wfirst_bresp got bvalid=%b bresp=%b required 1/00", axi.bvalid, axi.bresp);
    end
    tick();
    n_tests++;
    if (csr_data[63:32] !== m_csr[1] || m_csr[1] !== 32'h0000_A5A5) begin
      n_fail++; $display("FAIL wfirst_csr1 got=%h required=%h", csr_data[63:32], m_csr[1]);
    end
  endtask

  task automatic test_csr_random();
    logic [31:0] d, wd; logic [1:0] r; logic [3:0] s; int idx;
    for (int k = 0; k < 16; k++) begin
      idx = $urandom_range(0, NR - 1);
      wd = $urandom; s = 4'($urandom);
      axi_write(AW'(16 + 4 * idx + $urandom_range(0, 3)), wd, s, r);
      m_csr[idx] = merge(m_csr[idx], wd, s);
      n_tests++;
      if (r !== OKAY || csr_data !== csr_vec()) begin
        n_fail++; $display("FAIL csr_write[%0d] got resp=%b csr=%h required 00/%h", idx, r, csr_data, csr_vec());
      end
      idx = $urandom_range(0, NR - 1);
      axi_read(AW'(16 + 4 * idx), d, r);
      n_tests++;
      if (d !== m_csr[idx] || r !== OKAY) begin
        n_fail++; $display("FAIL csr_read[%0d] got=%h/%b required=%h/00", idx, d, r, m_csr[idx]);
      end
    end
  endtask

  task automatic test_p2l();
    logic [31:0] d, wd; logic [1:0] r, er;
    for (int k = 0; k < EL + 1; k++) begin
      wd = $urandom;
      er = (m_p2l.size() < EL) ? OKAY : SLVERR;
      axi_write(10'h004, wd, 4'($urandom), r);
      if (er == OKAY) m_p2l.push_back(wd);
      n_tests++;
      if (r !== er) begin
        n_fail++; $display("FAIL p2l_enq[%0d] got=%b required=%b", k, r, er);
      end
    end
    axi_read(10'h000, d, r);
    n_tests++;
    if (p2l_v !== 1'b1 || d !== 32'(EL - m_p2l.size()) || r !== OKAY) begin
      n_fail++; $display("FAIL p2l_full got v=%b free=%h/%b required 1/%h/00", p2l_v, d, r, EL - m_p2l.size());
    end
    // enqueue into a full FIFO on the same edge as a yumi
    wd = $urandom;
    axi.awaddr = 10'h004; axi.wdata = wd; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    n_tests++;
    if (p2l_data !== m_p2l[0]) begin
      n_fail++; $display("FAIL p2l_head got=%h required=%h", p2l_data, m_p2l[0]);
    end
    p2l_yumi = 1'b1;
    tick();
    p2l_yumi = 1'b0;
    void'(m_p2l.pop_front());
    m_p2l.push_back(wd);
    n_tests++;
    if (axi.bvalid !== 1'b1 || axi.bresp !== OKAY) begin
      n_fail++; $display("FAIL p2l_full_yumi got bvalid=%b bresp=%b required 1/00", axi.bvalid, axi.bresp);
    end
    tick();
    axi_read(10'h000, d, r);
    n_tests++;
    if (d !== 32'(EL - m_p2l.size())) begin
      n_fail++; $display("FAIL p2l_free_after got=%h required=%h", d, EL - m_p2l.size());
    end
    while (m_p2l.size() > 0) begin
      wd = m_p2l.pop_front();
      n_tests++;
      if (p2l_v !== 1'b1 || p2l_data !== wd) begin
        n_fail++; $display("FAIL p2l_drain got v=%b data=%h required 1/%h", p2l_v, p2l_data, wd);
      end
      p2l_yumi = 1'b1;
      tick();
      p2l_yumi = 1'b0;
    end
    n_tests++;
    if (p2l_v !== 1'b0) begin
      n_fail++; $display("FAIL p2l_empty got v=%b required 0", p2l_v);
    end
  endtask

  task automatic test_l2p();
    logic [31:0] d, e, wd; logic [1:0] r, er;
    for (int v = 1; v <= EL; v++) begin
      l2p_data = 32'(v); l2p_v = 1'b1;
      n_tests++;
      if (l2p_ready !== 1'b1) begin
        n_fail++; $display("FAIL l2p_ready[%0d] got=%b required=1", v, l2p_ready);
      end
      tick();
      m_l2p.push_back(32'(v));
      l2p_v = 1'b0;
    end
    n_tests++;
    if (l2p_ready !== 1'b0) begin
      n_fail++; $display("FAIL l2p_full_ready got=%b required=0", l2p_ready);
    end
    // host dequeue with a PL push pending on a full FIFO
    l2p_data = 32'h9; l2p_v = 1'b1;
    e = m_l2p.pop_front();
    m_l2p.push_back(32'h9);
    axi_read(10'h00C, d, r);
    l2p_v = 1'b0;
    n_tests++;
    if (d !== e || r !== OKAY || l2p_ready !== 1'b0) begin
      n_fail++; $display("FAIL l2p_pop_push got=%h/%b ready=%b required=%h/00 ready=0", d, r, l2p_ready, e);
    end
    axi_read(10'h008, d, r);
    n_tests++;
    if (d !== 32'(m_l2p.size())) begin
      n_fail++; $display("FAIL l2p_occ got=%h required=%h", d, m_l2p.size());
    end
    for (int k = 0; k < 24; k++) begin
      if (($urandom % 2 == 1) && m_l2p.size() < EL) begin
        wd = $urandom;
        l2p_data = wd; l2p_v = 1'b1;
        n_tests++;
        if (l2p_ready !== 1'b1) begin
          n_fail++; $display("FAIL l2p_rand_ready got=%b required=1", l2p_ready);
        end
        tick();
        l2p_v = 1'b0;
        m_l2p.push_back(wd);
      end else begin
        er = (m_l2p.size() > 0) ? OKAY : SLVERR;
        e = (m_l2p.size() > 0) ? m_l2p.pop_front() : 32'h0;
        axi_read(10'h00C, d, r);
        n_tests++;
        if (d !== e || r !== er) begin
          n_fail++; $display("FAIL l2p_rand_deq got=%h/%b required=%h/%b", d, r, e, er);
        end
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] d, e; logic [1:0] r;
    while (m_l2p.size() > 0) begin
      e = m_l2p.pop_front();
      axi_read(10'h00C, d, r);
      n_tests++;
      if (d !== e || r !== OKAY) begin
        n_fail++; $display("FAIL err_drain got=%h/%b required=%h/00", d, r, e);
      end
    end
    axi_read(10'h00C, d, r);
    n_tests++;
    if (d !== 32'h0 || r !== SLVERR) begin
      n_fail++; $display("FAIL err_deq_empty got=%h/%b required=0/10", d, r);
    end
    axi_read(10'h030, d, r);
    n_tests++;
    if (d !== 32'h0 || r !== SLVERR) begin
      n_fail++; $display("FAIL err_unmapped_rd got=%h/%b required=0/10", d, r);
    end
    axi_read(10'h004, d, r);
    n_tests++;
    if (d !== 32'h0 || r !== SLVERR) begin
      n_fail++; $display("FAIL err_wo_rd got=%h/%b required=0/10", d, r);
    end
    l2p_data = 32'h1234_5678; l2p_v = 1'b1;
    tick();
    l2p_v = 1'b0;
    m_l2p.push_back(32'h1234_5678);
    axi_write(10'h008, 32'hFFFF_FFFF, 4'hF, r);
    n_tests++;
    if (r !== SLVERR) begin
      n_fail++; $display("FAIL err_ro_wr got=%b required=10", r);
    end
    axi_read(10'h008, d, r);
    n_tests++;
    if (d !== 32'(m_l2p.size()) || r !== OKAY) begin
      n_fail++; $display("FAIL err_occ_unchanged got=%h/%b required=%h/00", d, r, m_l2p.size());
    end
    axi_write(10'h030, 32'hDEAD_BEEF, 4'hF, r);
    n_tests++;
    if (r !== SLVERR || csr_data !== csr_vec()) begin
      n_fail++; $display("FAIL err_unmapped_wr got=%b csr=%h required 10/%h", r, csr_data, csr_vec());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, d1, d2, d3; logic [1:0] r;
    d1 = $urandom; d2 = $urandom; d3 = $urandom;
    axi.bready = 1'b0;
    axi.awaddr = 10'h010; axi.wdata = d1; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    tick();
    m_csr[0] = d1;
    axi.awaddr = 10'h014; axi.wdata = d2; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    n_tests++;
    if (axi.bvalid !== 1'b1 || axi.awready !== 1'b1 || axi.wready !== 1'b1 || csr_data[31:0] !== m_csr[0]) begin
      n_fail++; $display("FAIL b2b_first got bvalid=%b awr=%b wr=%b csr0=%h required 1/1/1/%h",
                         axi.bvalid, axi.awready, axi.wready, csr_data[31:0], m_csr[0]);
    end
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    tick(); tick(); tick();
    n_tests++;
    if (axi.awready !== 1'b0 || axi.wready !== 1'b0 || axi.bvalid !== 1'b1 || csr_data[63:32] !== m_csr[1]) begin
      n_fail++; $display("FAIL b2b_held got awr=%b wr=%b bvalid=%b csr1=%h required 0/0/1/%h",
                         axi.awready, axi.wready, axi.bvalid, csr_data[63:32], m_csr[1]);
    end
    axi.bready = 1'b1;
    tick();
    n_tests++;
    if (axi.bvalid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_bhs got bvalid=%b required=0", axi.bvalid);
    end
    tick();
    m_csr[1] = d2;
    n_tests++;
    if (axi.bvalid !== 1'b1 || axi.bresp !== OKAY || csr_data[63:32] !== m_csr[1]) begin
      n_fail++; $display("FAIL b2b_second got bvalid=%b bresp=%b csr1=%h required 1/00/%h",
                         axi.bvalid, axi.bresp, csr_data[63:32], m_csr[1]);
    end
    tick();
    axi.bready = 1'b0;
    axi.awaddr = 10'h018; axi.wdata = d3; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    tick();
    m_csr[2] = d3;
    n_tests++;
    if (axi.bvalid !== 1'b1 || csr_data !== csr_vec()) begin
      n_fail++; $display("FAIL b2b_third got bvalid=%b csr=%h required 1/%h", axi.bvalid, csr_data, csr_vec());
    end
    aresetn = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (axi.bvalid !== 1'b0 || csr_data !== csr_vec() || axi.awready !== 1'b0 || p2l_v !== 1'b0) begin
      n_fail++; $display("FAIL b2b_reset got bvalid=%b awr=%b v=%b csr=%h required 0/0/0/%h",
                         axi.bvalid, axi.awready, p2l_v, csr_data, csr_vec());
    end
    tick(); tick();
    aresetn = 1'b1;
    axi.bready = 1'b1;
    tick();
    axi_read(10'h010, d, r);
    n_tests++;
    if (d !== m_csr[0] || r !== OKAY || axi.bvalid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_after_reset got=%h/%b bvalid=%b required=%h/00 bvalid=0", d, r, axi.bvalid, m_csr[0]);
    end
    axi_read(10'h008, d, r);
    n_tests++;
    if (d !== 32'(m_l2p.size())) begin
      n_fail++; $display("FAIL b2b_occ_after_reset got=%h required=%h", d, m_l2p.size());
    end
  endtask

  initial begin
    test_reset();
    test_w_before_aw();
    test_csr_random();
    test_p2l();
    test_l2p();
    test_errors();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish, required completion within 2ms");
    $fatal(1, "watchdog");
  end
endmodule
